fp_regfile_ctx_xfer: RTL and testbench

Context save/restore sequencer for the 32-entry floating-point register file. On command it performs one of two transfers to or from a word-aligned memory area, using a single-outstanding req/gnt/rvalid data-memory port.
- Save: reads F0..F31 through the register file's combinational read port and stores them.
- Restore: loads 32 words and writes them into F0..F31 through the register file's write port.

The core stalls while busy_o is high, so the block has exclusive use of both ports during a transfer.

---
 rtl/fp_regfile_ctx_xfer.sv | 130 +++++++++++++
 tb/tb_fp_regfile_ctx_xfer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_regfile_ctx_xfer.sv
// Context save/restore sequencer moving F0..F31 between the FP regfile and a word-aligned memory area.
// Latency: save 2 cycles/word, restore 3 cycles/word (gnt high, rvalid one cycle after gnt), plus a done cycle.
// Backpressure: a request is held with stable address/data until mem_gnt_i; restore waits for mem_rvalid_i.
module fp_regfile_ctx_xfer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4:0]            rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_RD  = 3'd1,
    SAVE_REQ = 3'd2,
    RST_REQ  = 3'd3,
    RST_WAIT = 3'd4,
    RST_WR   = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [4:0]            LAST_IDX   = 5'd31;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

  state_t                  state_q, state_d;
  logic [4:0]              idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  // State, word index, area base and the single data holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath updates; gnt/rvalid only steer registers, never outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i & ALIGN_MASK;
          idx_d   = 5'd0;
          state_d = mode_i ? RST_REQ : SAVE_RD;
        end
      end
      SAVE_RD: begin
        data_d  = rf_rdata_i;
        state_d = SAVE_REQ;
      end
      SAVE_REQ: begin
        if (mem_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = SAVE_RD;
          end
        end
      end
      RST_REQ: begin
        if (mem_gnt_i) begin
          state_d = RST_WAIT;
        end
      end
      RST_WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = RST_WR;
        end
      end
      RST_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = RST_REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state; addresses wrap modulo 2^ADDR_WIDTH.
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign rf_raddr_o  = idx_q;
  assign rf_we_o     = (state_q == RST_WR);
  assign rf_waddr_o  = idx_q;
  assign rf_wdata_o  = data_q;
  assign mem_req_o   = (state_q == SAVE_REQ) || (state_q == RST_REQ);
  assign mem_we_o    = (state_q == SAVE_REQ);
  assign mem_addr_o  = base_q + ADDR_WIDTH'({idx_q, 2'b00});
  assign mem_wdata_o = data_q;

endmodule

// File: tb/tb_fp_regfile_ctx_xfer.sv
// Bench for fp_regfile_ctx_xfer: regfile and memory models around the sequencer.
// Latency: done cycle checked against hand-computed counts per vector.
// Backpressure: memory model stalls gnt a configurable number of cycles per request.
module tb_fp_regfile_ctx_xfer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        mode_i;
  logic [31:0] base_addr_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  fp_regfile_ctx_xfer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  logic [31:0] rf [32];
  logic [31:0] mem [logic [31:0]];
  assign rf_rdata_i = rf[rf_raddr_o];

  int n_cmp = 0;
  int n_bad = 0;

  int          stall_cfg = 0;
  bit          spur_gnt = 1'b0;
  bit          spur_rv = 1'b0;
  logic [31:0] addr_log[$];
  int          n_st, n_ld, n_we, n_unstable;
  int          wait_cnt;
  bit          req_active, pend_ld, hold_we;
  logic [31:0] hold_addr, hold_wdata, pend_addr;

  typedef struct {
    bit          mode;
    logic [31:0] base;
    int          stall;
    bit          mid;
    bit          spur;
    int          exp_done;
    logic [31:0] addr0;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " busy_o"},      32'(busy_o),      32'h0);
    chk({tag, " done_o"},      32'(done_o),      32'h0);
    chk({tag, " rf_raddr_o"},  32'(rf_raddr_o),  32'h0);
    chk({tag, " rf_we_o"},     32'(rf_we_o),     32'h0);
    chk({tag, " rf_waddr_o"},  32'(rf_waddr_o),  32'h0);
    chk({tag, " rf_wdata_o"},  rf_wdata_o,       32'h0);
    chk({tag, " mem_req_o"},   32'(mem_req_o),   32'h0);
    chk({tag, " mem_we_o"},    32'(mem_we_o),    32'h0);
    chk({tag, " mem_addr_o"},  mem_addr_o,       32'h0);
    chk({tag, " mem_wdata_o"}, mem_wdata_o,      32'h0);
  endtask

  // Memory responder and regfile write model, acting 1 time unit after each edge.
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    wait_cnt = 0; req_active = 1'b0; pend_ld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_ld) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem.exists(pend_addr) ? mem[pend_addr] : 32'hBAD0BAD0;
        pend_ld      = 1'b0;
      end else begin
        mem_rvalid_i = spur_rv;
        mem_rdata_i  = 32'hDEADBEEF;
      end
      if (rf_we_o) begin
        n_we++;
        rf[rf_waddr_o] = rf_wdata_o;
      end
      if (mem_req_o) begin
        if (!req_active) begin
          req_active = 1'b1;
          hold_addr = mem_addr_o; hold_we = mem_we_o; hold_wdata = mem_wdata_o;
        end else if (mem_addr_o !== hold_addr || mem_we_o !== hold_we ||
                     (mem_we_o && mem_wdata_o !== hold_wdata)) begin
          n_unstable++;
        end
        if (wait_cnt < stall_cfg) begin
          mem_gnt_i = 1'b0;
          wait_cnt++;
        end else begin
          mem_gnt_i  = 1'b1;
          wait_cnt   = 0;
          req_active = 1'b0;
          addr_log.push_back(mem_addr_o);
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            n_st++;
          end else begin
            pend_ld = 1'b1;
            pend_addr = mem_addr_o;
            n_ld++;
          end
        end
      end else begin
        mem_gnt_i  = spur_gnt;
        req_active = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    n_st = 0; n_ld = 0; n_we = 0; n_unstable = 0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string       tag;
    logic [31:0] abase;
    int          cyc, done_cyc, bad_addr, bad_data;
    tag   = $sformatf("v%0d", id);
    abase = v.base & ~32'h3;
    mem.delete();
    for (int i = 0; i < 32; i++) begin
      if (v.mode) begin
        rf[i] = 32'h55550000 + 32'(i);
        mem[abase + 32'(4 * i)] = 32'hC0000000 | 32'(i);
      end else begin
        rf[i] = 32'h3F800000 + 32'(i);
      end
    end
    clear_logs();
    stall_cfg = v.stall; spur_gnt = v.spur; spur_rv = v.spur;
    start_i = 1'b1; mode_i = v.mode; base_addr_i = v.base;
    @(posedge clk); #1;
    start_i = 1'b0; base_addr_i = 32'h0;
    cyc = 1; done_cyc = -1;
    while (cyc < 400) begin
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (v.mid && cyc == 20) begin
        start_i = 1'b1; mode_i = ~v.mode; base_addr_i = 32'h5000;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done cycle"}, 32'(done_cyc), 32'(v.exp_done));
    // In the mid-start vector start_i is also raised during DONE; it must be ignored.
    start_i = v.mid;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({tag, " idle after done"}, 32'(busy_o), 32'h0);
    chk({tag, " txn count"}, 32'(addr_log.size()), 32'd32);
    chk({tag, " store/load count"}, 32'(v.mode ? n_ld : n_st), 32'd32);
    chk({tag, " wrong-direction count"}, 32'(v.mode ? n_st : n_ld), 32'd0);
    chk({tag, " rf_we pulses"}, 32'(n_we), v.mode ? 32'd32 : 32'd0);
    chk({tag, " unstable req cycles"}, 32'(n_unstable), 32'd0);
    chk({tag, " first addr"}, (addr_log.size() > 0) ? addr_log[0] : 32'hXXXXXXXX, v.addr0);
    bad_addr = 0; bad_data = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] !== abase + 32'(4 * i)) bad_addr++;
    for (int i = 0; i < 32; i++) begin
      if (v.mode) begin
        if (rf[i] !== (32'hC0000000 | 32'(i))) bad_data++;
      end else begin
        if (!mem.exists(abase + 32'(4 * i)) || mem[abase + 32'(4 * i)] !== 32'h3F800000 + 32'(i))
          bad_data++;
      end
    end
    chk({tag, " bad addresses"}, 32'(bad_addr), 32'd0);
    chk({tag, " bad data words"}, 32'(bad_data), 32'd0);
    if (v.base == 32'hFFFFFFF0)
      chk({tag, " wrapped addr idx4"}, (addr_log.size() > 4) ? addr_log[4] : 32'hXXXXXXXX, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, bad_new, bad_old, stray;
    vec_t v;

    //         mode  base           stall mid spur done  addr0
    vecs[0] = '{1'b0, 32'h00001000, 0, 1'b0, 1'b0, 65,  32'h00001000};
    vecs[1] = '{1'b1, 32'h00002000, 0, 1'b0, 1'b0, 97,  32'h00002000};
    vecs[2] = '{1'b0, 32'h00001000, 3, 1'b0, 1'b0, 161, 32'h00001000};
    vecs[3] = '{1'b0, 32'h00001003, 0, 1'b0, 1'b0, 65,  32'h00001000};
    vecs[4] = '{1'b0, 32'hFFFFFFF0, 0, 1'b0, 1'b0, 65,  32'hFFFFFFF0};
    vecs[5] = '{1'b0, 32'h00001000, 0, 1'b1, 1'b1, 65,  32'h00001000};
    vecs[6] = '{1'b1, 32'h00002000, 0, 1'b0, 1'b1, 97,  32'h00002000};
    vecs[7] = '{1'b1, 32'h00002000, 2, 1'b0, 1'b0, 161, 32'h00002000};

    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; base_addr_i = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of a restore, right as the tenth write is presented.
    for (int i = 0; i < 32; i++) rf[i] = 32'h11110000 + 32'(i);
    mem.delete();
    for (int i = 0; i < 32; i++) mem[32'h3000 + 32'(4 * i)] = 32'hA5000000 | 32'(i);
    clear_logs();
    stall_cfg = 0; spur_gnt = 1'b0; spur_rv = 1'b0;
    start_i = 1'b1; mode_i = 1'b1; base_addr_i = 32'h3000;
    @(posedge clk); #2;
    start_i = 1'b0;
    k = 0;
    while (n_we < 10 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("midreset reached 10 writes", 32'(n_we), 32'd10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    stray = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (mem_req_o || rf_we_o || busy_o) stray++;
    end
    chk("midreset stray activity", 32'(stray), 32'd0);
    chk("midreset total writes", 32'(n_we), 32'd10);
    bad_new = 0; bad_old = 0;
    for (int i = 0; i < 10; i++)  if (rf[i] !== (32'hA5000000 | 32'(i))) bad_new++;
    for (int i = 10; i < 32; i++) if (rf[i] !== 32'h11110000 + 32'(i)) bad_old++;
    chk("midreset restored F0..F9", 32'(bad_new), 32'd0);
    chk("midreset untouched F10..F31", 32'(bad_old), 32'd0);

    v = '{1'b0, 32'h00004000, 0, 1'b0, 1'b0, 65, 32'h00004000};
    run_vec(v, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
